// File: rtl/drm_fifo_pkg.sv
// Shared widths and types for the DRM-backed FIFO controller and its output queue.
package drm_fifo_pkg;
   localparam int DATA_W   = 21;
   localparam int ADDR_W   = 6;
   localparam int OQ_DEPTH = 2;

   typedef logic [ADDR_W:0]   ptr_t;
   typedef logic [DATA_W-1:0] data_t;

   localparam ptr_t RAM_DEPTH = ptr_t'(1 << ADDR_W);
endpackage

// File: rtl/drm_fifo_if.sv
// Producer/consumer valid-ready streams around the DRM FIFO controller.
interface drm_fifo_if;
   logic                s_valid;
   logic                s_ready;
   drm_fifo_pkg::data_t s_data;
   logic                m_valid;
   logic                m_ready;
   drm_fifo_pkg::data_t m_data;

   modport slave  (input  s_valid, s_data, m_ready,
                   output s_ready, m_valid, m_data);
   modport master (output s_valid, s_data, m_ready,
                   input  s_ready, m_valid, m_data);
endinterface

// File: rtl/drm_fifo_oq.sv
// Two-entry first-word-fall-through queue that absorbs the one-cycle DRM read latency.
module drm_fifo_oq
   import drm_fifo_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       push,
   input  data_t      push_data,
   input  logic       pop,
   output data_t      head,
   output logic [1:0] count
);

   data_t tail;

   // Head is always entry 0, so m_data comes straight from a register and never moves while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= push_data;
               else               tail <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head <= push_data;
               end else begin
                  head <= tail;
                  tail <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/drm_fifo_ctrl.sv
// Synchronous FIFO controller sequencing a 21x64 simple dual-port DRM with a 2-entry FWFT output queue.
module drm_fifo_ctrl
   import drm_fifo_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   drm_fifo_if.slave         bus,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output data_t             ram_wr_data,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  data_t             ram_rd_data,
   output logic              ram_rst,
   output logic              full,
   output logic              empty,
   output ptr_t              count
);

   ptr_t       wr_ptr;
   ptr_t       rd_ptr;
   ptr_t       ram_used;
   logic       inflight;
   logic       push;
   logic       pop;
   logic       issue;
   logic [1:0] oq_count;
   logic [2:0] oq_load;

   assign ram_rst     = ~rst_n;
   assign ram_used    = wr_ptr - rd_ptr;
   assign full        = (ram_used == RAM_DEPTH);
   assign empty       = (count == '0);

   assign bus.s_ready = !full && !flush;
   assign bus.m_valid = (oq_count != 2'd0);
   assign push        = bus.s_valid && bus.s_ready;
   assign pop         = bus.m_valid && bus.m_ready;

   assign ram_wr_en   = push && rst_n;
   assign ram_wr_addr = wr_ptr[ADDR_W-1:0];
   assign ram_wr_data = bus.s_data;
   assign ram_rd_addr = rd_ptr[ADDR_W-1:0];

   // Only issue a read when its word is guaranteed a queue slot on arrival; a same-cycle pop frees one.
   assign oq_load = {1'b0, oq_count} + {2'b0, inflight};
   assign issue   = !flush && (ram_used != '0) &&
                    (oq_load < 3'(OQ_DEPTH) + {2'b0, pop});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         inflight <= 1'b0;
         count    <= '0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         inflight <= 1'b0;
         count    <= '0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + ptr_t'(1);
         if (issue) rd_ptr <= rd_ptr + ptr_t'(1);
         inflight <= issue;
         count    <= count + ptr_t'(push) - ptr_t'(pop);
      end
   end

   drm_fifo_oq u_oq (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (inflight),
      .push_data (ram_rd_data),
      .pop       (pop),
      .head      (bus.m_data),
      .count     (oq_count)
   );

endmodule

// File: doc/drm_fifo_ctrl.md
Name: drm_fifo_ctrl

Overview:
- Single-clock synchronous FIFO controller that sequences the 21-bit x 64-deep simple dual-port DRM (drm_21x64).
- The DRM is configured with synchronous read, no output register and asynchronous reset.
- The controller owns both DRM ports. It presents valid/ready streams upstream and downstream, and hides the one-cycle RAM read latency behind a 2-entry first-word-fall-through output queue.
- It sits between a producer and a consumer in the fabric datapath. The DRM is instantiated beside it, with wr_clk and rd_clk both tied to clk.

Parameters:
- DATA_W, 21, payload width; must equal the DRM data width.
- ADDR_W, 6, DRM address width; RAM depth is 2**ADDR_W = 64.
- OQ_DEPTH, 2, output queue entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  single clock; drives the controller and both DRM clocks.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all contents.
- s_valid  in  1  producer has data.
- s_ready  out  1  controller accepts; equals !full.
- s_data  in  DATA_W  producer payload.
- m_valid  out  1  head entry valid.
- m_ready  in  1  consumer accepts.
- m_data  out  DATA_W  head payload, from the output queue register.
- ram_wr_en  out  1  to DRM wr_en.
- ram_wr_addr  out  ADDR_W  to DRM wr_addr.
- ram_wr_data  out  DATA_W  to DRM wr_data.
- ram_rd_addr  out  ADDR_W  to DRM rd_addr.
- ram_rd_data  in  DATA_W  from DRM rd_data; valid one cycle after ram_rd_addr is sampled.
- ram_rst  out  1  to DRM wr_rst/rd_rst; equals ~rst_n.
- full  out  1  RAM occupancy == 64.
- empty  out  1  total count == 0.
- count  out  ADDR_W+1  total entries: RAM + in-flight + output queue, range 0..66.

Behaviour:
- Reset (rst_n=0, async):
  - Write pointer, read pointer, ram_used, inflight and the output queue all clear to 0.
  - Outputs: s_ready=1, m_valid=0, m_data=0, ram_wr_en=0, full=0, empty=1, count=0.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits wide.
  - ram_used = wr_ptr - rd_ptr, computed modulo 2**(ADDR_W+1).
  - The address is ptr[ADDR_W-1:0]; addresses wrap 63 -> 0 with no gap.
- Push:
  - Occurs when s_valid & s_ready.
  - Combinational outputs: ram_wr_en=1, ram_wr_addr=wr_ptr, ram_wr_data=s_data.
  - wr_ptr increments at the clock edge.
- Read issue:
  - ram_rd_addr = rd_ptr[ADDR_W-1:0] at all times.
  - issue = (ram_used != 0) & (oq_count + inflight - pop < OQ_DEPTH), where pop = m_valid & m_ready.
  - On issue, rd_ptr increments and inflight is set to 1 for the next cycle; otherwise inflight = 0.
  - ram_used is the registered value, so a word written in cycle t is first issuable in cycle t+1. The DRM same-address read-during-write case therefore never occurs.
- Capture:
  - When inflight=1, ram_rd_data is written into the output queue tail in that cycle.
  - A simultaneous pop frees the head in the same edge.
- Latency:
  - Push into an empty FIFO at cycle 0 gives issue at cycle 1, RAM data at cycle 2, and m_valid=1 at cycle 3.
  - Steady-state throughput is 1 word per cycle in both directions.
- Capacity:
  - full = (ram_used == 64).
  - Up to 2 further words are held in the output queue, so the observable maximum is count=66.
  - A freed RAM slot is writable the cycle after issue; this is safe because the read was sampled at the issue edge.
- Simultaneous push + pop at full: the push is refused (s_ready=0). The pop proceeds, and s_ready rises the cycle after the next issue.
- Output queue:
  - Head register drives m_data.
  - m_data holds steady while m_valid & !m_ready (AXI-style stability).
- Flush:
  - Takes effect at the edge: clears pointers, inflight and the output queue, giving count=0, m_valid=0.
  - Flush has priority over a push/pop/capture in the same cycle; those are discarded.
  - While flush=1: ram_wr_en=0 and s_ready=0.
- Reset mid-operation: all state is lost. No RAM clearing is needed, since stale RAM data is never exposed.
- count is the registered sum ram_used + inflight + oq_count.

Decomposition:
- Shared package drm_fifo_pkg:
  - DATA_W and ADDR_W constants.
  - ptr_t, an (ADDR_W+1)-bit type.
  - data_t, a DATA_W-bit type.
- One sub-module, drm_fifo_oq: the 2-entry FWFT output queue, with push (capture), pop, head data, count and flush.
- The pointer/issue logic stays at top level. The DRM itself is instantiated by the parent, not inside this block.

Test Plan:
- Push 0x000001 once into the empty FIFO at cycle 0 -> m_valid rises at cycle 3 with m_data=0x000001; count reads 1 from cycle 1 onward; empty=0 from cycle 1.
- Hold m_ready=0 and push 66 words 0..65 -> full=1 after 64 RAM-resident words; count=66; s_ready=0; the 67th word is refused; drain gives values 0..65 in order.
- Continuous push and pop of 200 incrementing words with m_ready=1 -> 1 word/cycle after the 3-cycle fill; addresses wrap 63->0 at least 3 times; no loss or duplication.
- Random s_valid/m_ready at 50% for 5000 cycles against a scoreboard -> order preserved; m_data stable while stalled; count matches the model every cycle.
- At count=40, assert flush for one cycle while pushing and popping -> next cycle count=0, m_valid=0, empty=1; the pushed word is discarded; the following push of 0x1ABCDE emerges 3 cycles later.
- Drop rst_n asynchronously mid-burst (count=20) -> outputs return to reset values immediately; ram_rst=1 while reset is held; after release, a push of 0x155555 emerges correctly.
